// File: rtl/spike_generator.sv
// spike_generator: threshold/fire/refractory stage that follows the neuron accumulator.
// It compares each accepted IEEE-754 membrane potential against THRESHOLD and, on a
// fire, emits a one-cycle spike with an accumulator clear. The neuron then stays
// refractory for REFRACT_CYCLES cycles.
// Optional feature macro: SPIKE_COUNT_EN adds a saturating 16-bit spike counter
// (spike_count) and its synchronous clear input (count_clr).
// Every output is registered. Each output is computed from the next state, so it
// is valid during the same cycle as the state it describes.
module spike_generator #(
    parameter logic [31:0] THRESHOLD      = 32'h3F80_0000,
    parameter int          REFRACT_CYCLES = 4,
    parameter int          CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] potential,
    input  logic        potential_valid,
    output logic        potential_ready,
    output logic        spike,
    output logic        acc_clear,
    output logic        refractory,
    output logic        exception,
`ifdef SPIKE_COUNT_EN
    input  logic        count_clr,
    output logic [15:0] spike_count,
`endif
    output logic        in_drop
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        FIRE    = 2'd2,
        REFRACT = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [31:0]        latched;
    logic [CNT_W-1:0]   cnt;

    // Decoded fields of the latched potential
    logic               lat_special;
    logic               lat_negative;
    logic               lat_over;

    // Next-cycle values of the registered outputs
    logic               ready_d;
    logic               spike_d;
    logic               refr_d;
    logic               exc_d;

    // Because the sign bit is handled separately, the magnitude compare is an
    // unsigned compare of bits [30:0]. This is monotonic for zero, denormals and
    // normals alike.
    assign lat_special  = (latched[30:23] == 8'hFF);
    assign lat_negative = latched[31];
    assign lat_over     = (latched[30:0] >= THRESHOLD[30:0]);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (potential_valid) next_state = COMPARE;
            COMPARE: begin
                if (lat_special)       next_state = IDLE;
                else if (lat_negative) next_state = IDLE;
                else if (lat_over)     next_state = FIRE;
                else                   next_state = IDLE;
            end
            FIRE:    next_state = (REFRACT_CYCLES == 0) ? IDLE : REFRACT;
            REFRACT: if (cnt <= CNT_W'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode; the result is registered below
    always_comb begin
        ready_d = (next_state == IDLE);
        spike_d = (next_state == FIRE);
        refr_d  = (next_state == REFRACT);
        exc_d   = (state == COMPARE) && lat_special;
    end

    // Registered outputs. A drop is flagged when valid arrives while ready is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            potential_ready <= 1'b1;
            spike           <= 1'b0;
            acc_clear       <= 1'b0;
            refractory      <= 1'b0;
            exception       <= 1'b0;
            in_drop         <= 1'b0;
        end else begin
            potential_ready <= ready_d;
            spike           <= spike_d;
            acc_clear       <= spike_d;
            refractory      <= refr_d;
            exception       <= exc_d;
            in_drop         <= potential_valid && !potential_ready;
        end
    end

    // Latch the potential only on acceptance in IDLE. Dropped values never land here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              latched <= 32'h0;
        else if (state == IDLE && potential_valid) latched <= potential;
    end

    // Refractory down-counter: loaded when leaving FIRE, and it counts down while refractory
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  cnt <= '0;
        else if (state == FIRE)                      cnt <= CNT_W'(REFRACT_CYCLES);
        else if (state == REFRACT && cnt != '0)      cnt <= cnt - CNT_W'(1);
    end

`ifdef SPIKE_COUNT_EN
    // Saturating spike counter. A clear wins over a coincident FIRE increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                     spike_count <= 16'h0;
        else if (count_clr)                             spike_count <= 16'h0;
        else if (state == FIRE && spike_count != 16'hFFFF) spike_count <= spike_count + 16'h1;
    end
`endif

endmodule

// File: tb/tb_spike_generator.sv
// Directed bench for spike_generator: a vector table of single potentials with
// hand-computed outcomes, plus sequences for back-pressure drops, async reset
// during refractory and (when SPIKE_COUNT_EN is defined) the spike counter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spike_generator;

    logic        clk;
    logic        reset;
    logic [31:0] potential;
    logic        potential_valid;
    logic        potential_ready;
    logic        spike;
    logic        acc_clear;
    logic        refractory;
    logic        exception;
    logic        in_drop;
`ifdef SPIKE_COUNT_EN
    logic        count_clr;
    logic [15:0] spike_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    spike_generator dut (
        .clk             (clk),
        .reset           (reset),
        .potential       (potential),
        .potential_valid (potential_valid),
        .potential_ready (potential_ready),
        .spike           (spike),
        .acc_clear       (acc_clear),
        .refractory      (refractory),
        .exception       (exception),
`ifdef SPIKE_COUNT_EN
        .count_clr       (count_clr),
        .spike_count     (spike_count),
`endif
        .in_drop         (in_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] p;
        logic        fire;
        logic        exc;
        string       name;
    } vec_t;

    vec_t vecs[12];

    // Drive one potential for a single cycle from IDLE and check every cycle of the
    // response: the COMPARE cycle, then FIRE+REFRACTORY (4 cycles)+IDLE, or the
    // return to IDLE with an optional exception pulse.
    task automatic run_sample(input logic [31:0] p, input logic fire, input logic exc,
                              input string name, input logic clr_on_fire);
        @(negedge clk);
        check({name, ".idle_ready"}, 32'(potential_ready), 32'd1);
        potential       = p;
        potential_valid = 1'b1;
        @(negedge clk);              // COMPARE cycle
        potential_valid = 1'b0;
        check({name, ".cmp_ready"}, 32'(potential_ready), 32'd0);
        check({name, ".cmp_spike"}, 32'(spike), 32'd0);
        @(negedge clk);
        if (fire) begin
            check({name, ".spike"},     32'(spike),      32'd1);
            check({name, ".acc_clear"}, 32'(acc_clear),  32'd1);
            check({name, ".fire_rdy"},  32'(potential_ready), 32'd0);
            check({name, ".fire_exc"},  32'(exception),  32'd0);
`ifdef SPIKE_COUNT_EN
            count_clr = clr_on_fire;
`endif
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
`ifdef SPIKE_COUNT_EN
                count_clr = 1'b0;
`endif
                check({name, ".refr"},       32'(refractory), 32'd1);
                check({name, ".refr_spike"}, 32'(spike),      32'd0);
                check({name, ".refr_rdy"},   32'(potential_ready), 32'd0);
            end
            @(negedge clk);
            check({name, ".refr_end"}, 32'(refractory), 32'd0);
            check({name, ".back_rdy"}, 32'(potential_ready), 32'd1);
        end else begin
            check({name, ".no_spike"}, 32'(spike),      32'd0);
            check({name, ".no_clr"},   32'(acc_clear),  32'd0);
            check({name, ".exc"},      32'(exception),  32'(exc));
            check({name, ".rdy"},      32'(potential_ready), 32'd1);
            check({name, ".no_refr"},  32'(refractory), 32'd0);
            @(negedge clk);
            check({name, ".exc_gone"}, 32'(exception),  32'd0);
        end
        if (clr_on_fire) check({name, ".unused"}, 32'(fire), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{32'h4000_0000, 1'b1, 1'b0, "two"};
        vecs[1]  = '{32'h3F00_0000, 1'b0, 1'b0, "half"};
        vecs[2]  = '{32'h3F80_0000, 1'b1, 1'b0, "equal"};
        vecs[3]  = '{32'h3F7F_FFFF, 1'b0, 1'b0, "just_below"};
        vecs[4]  = '{32'h7F80_0000, 1'b0, 1'b1, "pos_inf"};
        vecs[5]  = '{32'h7FC0_0000, 1'b0, 1'b1, "nan"};
        vecs[6]  = '{32'hC000_0000, 1'b0, 1'b0, "neg_two"};
        vecs[7]  = '{32'h0000_0000, 1'b0, 1'b0, "pos_zero"};
        vecs[8]  = '{32'h8000_0000, 1'b0, 1'b0, "neg_zero"};
        vecs[9]  = '{32'h0000_0001, 1'b0, 1'b0, "denorm"};
        vecs[10] = '{32'h7F7F_FFFF, 1'b1, 1'b0, "max_norm"};
        vecs[11] = '{32'hFF80_0000, 1'b0, 1'b1, "neg_inf"};

        reset           = 1'b0;
        potential       = 32'h0;
        potential_valid = 1'b0;
`ifdef SPIKE_COUNT_EN
        count_clr       = 1'b0;
`endif
        #12;
        check("rst.ready",      32'(potential_ready), 32'd1);
        check("rst.spike",      32'(spike),           32'd0);
        check("rst.acc_clear",  32'(acc_clear),       32'd0);
        check("rst.refractory", 32'(refractory),      32'd0);
        check("rst.exception",  32'(exception),       32'd0);
        check("rst.in_drop",    32'(in_drop),         32'd0);
`ifdef SPIKE_COUNT_EN
        check("rst.count",      32'(spike_count),     32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++)
            run_sample(vecs[i].p, vecs[i].fire, vecs[i].exc, vecs[i].name, 1'b0);

        // Hold valid through a spike; every non-ready cycle is flagged one cycle later
        @(negedge clk);
        potential       = 32'h4000_0000;
        potential_valid = 1'b1;
        @(negedge clk);              // COMPARE of 2.0
        potential = 32'h4040_0000;   // 3.0 stays valid from here on
        check("drop.cmp_in_drop", 32'(in_drop), 32'd0);
        @(negedge clk);              // FIRE
        check("drop.spike1",  32'(spike),   32'd1);
        check("drop.fire_dr", 32'(in_drop), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drop.refr",    32'(refractory), 32'd1);
            check("drop.refr_dr", 32'(in_drop),    32'd1);
        end
        @(negedge clk);              // IDLE: 3.0 is accepted at the next edge
        check("drop.idle_rdy", 32'(potential_ready), 32'd1);
        check("drop.idle_dr",  32'(in_drop),         32'd1);
        @(negedge clk);              // COMPARE of 3.0
        potential_valid = 1'b0;
        check("drop.cmp2_rdy", 32'(potential_ready), 32'd0);
        check("drop.cmp2_dr",  32'(in_drop),         32'd0);
        @(negedge clk);
        check("drop.spike2",   32'(spike),   32'd1);
        check("drop.fire2_dr", 32'(in_drop), 32'd0);
        repeat (6) @(negedge clk);
        check("drop.final_rdy", 32'(potential_ready), 32'd1);

        // Asynchronous reset in the middle of the refractory period
        potential       = 32'h4000_0000;
        potential_valid = 1'b1;
        @(negedge clk);
        potential_valid = 1'b0;
        repeat (3) @(negedge clk);   // FIRE, then refractory cycle 2
        check("arst.pre_refr", 32'(refractory), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("arst.refr",  32'(refractory),      32'd0);
        check("arst.ready", 32'(potential_ready), 32'd1);
        check("arst.spike", 32'(spike),           32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("arst.no_spike", 32'(spike),      32'd0);
        check("arst.idle",     32'(refractory), 32'd0);
        run_sample(32'h4000_0000, 1'b1, 1'b0, "post_rst", 1'b0);

`ifdef SPIKE_COUNT_EN
        // Start from a clean count after reset, then do three spikes and one clear on FIRE
        @(negedge clk);
        reset = 1'b0;
        #1 check("cnt.rst", 32'(spike_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++)
            run_sample(32'h4000_0000, 1'b1, 1'b0, "cnt", 1'b0);
        check("cnt.three", 32'(spike_count), 32'd3);
        run_sample(32'h4000_0000, 1'b1, 1'b0, "cnt_clr", 1'b1);
        check("cnt.cleared", 32'(spike_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
